// File: rtl/mpmc10_app_cmd_issue.sv
// ---------------------------------------------------------------------------
// mpmc10_app_cmd_issue
//
// Purpose:
//   Drives the DDR3 MIG application command port (app_en / app_cmd /
//   app_addr) for the multi-port memory controller. One burst request
//   (command, start address, beat count) is taken over a valid/ready
//   handshake. The block then issues one MIG command per beat and honours
//   app_rdy back-pressure. app_cmd and app_addr only change while app_en is
//   low, or on a beat the MIG has accepted.
//
// Ports:
//   i_clk        controller clock (MIG ui_clk)
//   i_rst_n      asynchronous, active-low reset
//   i_req_valid  burst request present
//   o_req_ready  block can accept a request (high only in IDLE)
//   i_req_cmd    MIG command for the whole burst
//   i_req_addr   start address of the burst
//   i_req_cnt    beats minus one (0 = single beat)
//   o_app_en     MIG command enable
//   o_app_cmd    MIG command
//   o_app_addr   MIG address
//   i_app_rdy    MIG accepts the command when app_en & app_rdy at posedge
//   o_beat       one-cycle pulse per accepted beat
//   o_done       one-cycle pulse after the final beat is accepted
//   o_busy       high in SETUP or ISSUE
// ---------------------------------------------------------------------------
module mpmc10_app_cmd_issue #(
  parameter int         AW        = 29,
  parameter int         CW        = 6,
  parameter int         ADDR_INC  = 8,
  parameter logic [2:0] CMD_WRITE = 3'b000,
  parameter logic [2:0] CMD_READ  = 3'b001
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [2:0]    i_req_cmd,
  input  logic [AW-1:0] i_req_addr,
  input  logic [CW-1:0] i_req_cnt,
  output logic          o_app_en,
  output logic [2:0]    o_app_cmd,
  output logic [AW-1:0] o_app_addr,
  input  logic          i_app_rdy,
  output logic          o_beat,
  output logic          o_done,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  // Parameter sanity: the idle encoding must not alias the read command,
  // otherwise an idle port would look like a pending read to anyone
  // snooping app_cmd. A zero increment would reissue one address forever.
  if (CMD_READ == CMD_WRITE) begin : g_bad_cmd_encoding
    $error("mpmc10_app_cmd_issue: CMD_READ and CMD_WRITE must differ");
  end
  if (ADDR_INC <= 0) begin : g_bad_addr_inc
    $error("mpmc10_app_cmd_issue: ADDR_INC must be positive");
  end

  state_t        r_state;
  logic          r_app_en;
  logic [2:0]    r_app_cmd;
  logic [AW-1:0] r_app_addr;
  logic          r_beat;
  logic          r_done;
  logic [CW-1:0] r_remaining;

  // A beat is accepted only when the MIG sees enable and ready together.
  // r_app_en is only ever high in ISSUE, so app_rdy in IDLE/SETUP is inert.
  logic w_accept;
  logic w_last;

  assign w_accept = r_app_en & i_app_rdy;
  assign w_last   = (r_remaining == '0);

  // Control FSM plus all registered outputs. The address increment wraps
  // modulo 2^AW through natural truncation of the AW-bit sum.
  // On the final beat the command returns to the write encoding so the
  // idle port always looks the same, but the address is left alone so the
  // last issued address stays visible for debug.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_app_en    <= 1'b0;
      r_app_cmd   <= CMD_WRITE;
      r_app_addr  <= '0;
      r_beat      <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_beat <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_app_cmd   <= i_req_cmd;
            r_app_addr  <= i_req_addr;
            r_remaining <= i_req_cnt;
            r_state     <= S_SETUP;
          end
        end
        // Enable stays low for this one cycle so the freshly latched
        // command and address are stable before the MIG ever samples them.
        S_SETUP: begin
          r_app_en <= 1'b1;
          r_state  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_beat <= 1'b1;
            if (w_last) begin
              r_app_en  <= 1'b0;
              r_app_cmd <= CMD_WRITE;
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_remaining <= r_remaining - 1'b1;
              r_app_addr  <= r_app_addr + AW'(ADDR_INC);
            end
          end
        end
        default: begin
          r_app_en <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and busy are decoded straight from the state register so a
  // request can be taken in the same cycle that done is reported.
  assign o_req_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);

  assign o_app_en   = r_app_en;
  assign o_app_cmd  = r_app_cmd;
  assign o_app_addr = r_app_addr;
  assign o_beat     = r_beat;
  assign o_done     = r_done;

endmodule
